// File: rtl/uart_block_rx_if.sv
// Signal bundle between the serial block receiver and its consumer.
// The receiver uses the slave modport. The line driver and block consumer use the master modport.
interface uart_block_rx_if;
    logic        rx_in;
    logic [63:0] data_out;
    logic        data_valid;
    logic        frame_error;
    logic        timeout;
    logic        busy;

    modport master (
        output rx_in,
        input  data_out,
        input  data_valid,
        input  frame_error,
        input  timeout,
        input  busy
    );

    modport slave (
        input  rx_in,
        output data_out,
        output data_valid,
        output frame_error,
        output timeout,
        output busy
    );
endinterface

// File: rtl/uart_block_rx.sv
// 8N1 UART receiver that packs eight bytes (first byte in the top byte) into one 64-bit block.
// Framing errors and inter-byte timeouts discard any partial block.
module uart_block_rx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input logic            clock,
    input logic            reset,
    uart_block_rx_if.slave bus
);
    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam int unsigned ToW   = $clog2(TIMEOUT_BITS * CLKS_PER_BIT);

    localparam logic [BaudW-1:0] HalfLast = BaudW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BaudW-1:0] BitLast  = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [ToW-1:0]   ToLast   = ToW'(TIMEOUT_BITS * CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e            state_q, state_d;
    logic              rx_meta_q, rx_s_q;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        byte_q, byte_d;
    logic [63:0]       asm_q, asm_d;
    logic [ToW-1:0]    to_q, to_d;
    logic              load_q, load_d;
    logic [63:0]       data_out_q;
    logic              data_valid_q;
    logic              frame_error_q, frame_error_d;
    logic              timeout_q, timeout_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            state_q       <= StIdle;
            baud_q        <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            byte_q        <= '0;
            asm_q         <= '0;
            to_q          <= '0;
            load_q        <= 1'b0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            rx_meta_q     <= bus.rx_in;
            rx_s_q        <= rx_meta_q;
            state_q       <= state_d;
            baud_q        <= baud_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            byte_q        <= byte_d;
            asm_q         <= asm_d;
            to_q          <= to_d;
            load_q        <= load_d;
            data_valid_q  <= load_q;
            if (load_q) data_out_q <= asm_q;
            frame_error_q <= frame_error_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        baud_d        = baud_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        byte_d        = byte_q;
        asm_d         = asm_q;
        to_d          = to_q;
        load_d        = 1'b0;
        frame_error_d = 1'b0;
        timeout_d     = 1'b0;

        case (state_q)
            StIdle: begin
                baud_d = '0;
                if (byte_q == 3'd0) begin
                    to_d = '0;
                end else if (to_q == ToLast) begin
                    to_d      = '0;
                    byte_d    = '0;
                    asm_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    to_d = to_q + 1'b1;
                end
                // A start edge coinciding with the timeout begins a fresh block.
                if (!rx_s_q) begin
                    state_d = StStart;
                    to_d    = '0;
                end
            end
            StStart: begin
                if (baud_q == HalfLast) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = rx_s_q ? StIdle : StData;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_q == BitLast) begin
                    baud_d  = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = StStop;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_q == BitLast) begin
                    baud_d = '0;
                    if (rx_s_q) begin
                        asm_d   = {asm_q[55:0], shift_q};
                        byte_d  = byte_q + 1'b1;
                        load_d  = (byte_q == 3'd7);
                        state_d = StIdle;
                    end else begin
                        frame_error_d = 1'b1;
                        byte_d        = '0;
                        asm_d         = '0;
                        state_d       = StBreak;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StBreak: begin
                if (rx_s_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.data_out    = data_out_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.frame_error = frame_error_q;
    assign bus.timeout     = timeout_q;
    assign bus.busy        = (state_q != StIdle) || (byte_q != 3'd0);
endmodule
